// File: rtl/imem_responder.sv
// Instruction-fetch responder: word-addressed instruction array with a write
// (load) port, fixed-latency in-order fetch responses, credit flow control
// and flush.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fetch_addr, fetch_req     fetch request (byte address, valid)
//   fetch_ready               request accepted when fetch_req && fetch_ready
//   request_data, fetch_error response word and error flag (registered)
//   fetch_data_valid          response valid (registered)
//   resp_ready                consumer takes the head response
//   flush                     drop every outstanding request and response
//   load_en/addr/data         instruction array write port
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_req,
    output logic        fetch_ready,
    output logic [31:0] request_data,
    output logic        fetch_data_valid,
    output logic        fetch_error,
    input  logic        resp_ready,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [31:0] mem [DEPTH_WORDS];

    // Word offsets from the base; below-base addresses are caught separately.
    logic [29:0] fetch_off;
    logic [29:0] load_off;
    logic        fetch_bad;
    logic        load_bad;
    logic [31:0] rd_data;

    assign fetch_off = fetch_addr[31:2] - BASE_ADDR[31:2];
    assign load_off  = load_addr[31:2] - BASE_ADDR[31:2];
    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr < BASE_ADDR)
                       || (fetch_off >= 30'(DEPTH_WORDS));
    assign load_bad  = (load_addr[1:0] != 2'b00) || (load_addr < BASE_ADDR)
                       || (load_off >= 30'(DEPTH_WORDS));
    // Asynchronous read in the accept cycle gives read-before-write ordering.
    assign rd_data   = fetch_bad ? 32'h0 : mem[fetch_off[IDX_W-1:0]];

    // Array write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (load_en && !load_bad) begin
            mem[load_off[IDX_W-1:0]] <= load_data;
        end
    end

    // Credits
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             pop;

    assign fetch_ready = !rst && !flush && (cnt < CNT_W'(QUEUE_DEPTH));
    assign accept      = fetch_req && fetch_ready;
    assign pop         = fetch_data_valid && resp_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !accept) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Latency pipe: LATENCY-1 register stages; the output register is the last.
    logic        arr_valid;
    logic [31:0] arr_data;
    logic        arr_err;

    if (LATENCY > 1) begin : g_pipe
        logic [LATENCY-2:0] pv;
        logic [LATENCY-2:0] pe;
        logic [31:0]        pd [LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                pv <= '0;
            end else begin
                pv[0] <= accept;
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    pv[i] <= pv[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            pe[0] <= fetch_bad;
            pd[0] <= rd_data;
            for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end

        assign arr_valid = pv[LATENCY-2];
        assign arr_err   = pe[LATENCY-2];
        assign arr_data  = pd[LATENCY-2];
    end else begin : g_nopipe
        assign arr_valid = accept;
        assign arr_err   = fetch_bad;
        assign arr_data  = rd_data;
    end

    // Response queue behind the output register.
    logic [31:0]      fifo_data [QUEUE_DEPTH];
    logic             fifo_err  [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             out_free;
    logic             out_load_fifo;
    logic             out_load_arr;
    logic             fifo_push;
    logic             fifo_pop;

    // Refill the output register from the queue first, else from the pipe.
    always_comb begin
        out_load_fifo = 1'b0;
        out_load_arr  = 1'b0;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        out_free      = !fetch_data_valid || pop;
        if (out_free) begin
            if (fifo_cnt != '0) begin
                out_load_fifo = 1'b1;
                fifo_pop      = 1'b1;
                fifo_push     = arr_valid;
            end else begin
                out_load_arr  = arr_valid;
            end
        end else begin
            fifo_push = arr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push && !rst && !flush) begin
            fifo_data[wr_ptr] <= arr_data;
            fifo_err[wr_ptr]  <= arr_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_cnt         <= '0;
            fetch_data_valid <= 1'b0;
            fetch_error      <= 1'b0;
            request_data     <= 32'h0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (fifo_pop && !fifo_push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
            if (out_load_fifo) begin
                fetch_data_valid <= 1'b1;
                request_data     <= fifo_data[rd_ptr];
                fetch_error      <= fifo_err[rd_ptr];
            end else if (out_load_arr) begin
                fetch_data_valid <= 1'b1;
                request_data     <= arr_data;
                fetch_error      <= arr_err;
            end else if (out_free) begin
                fetch_data_valid <= 1'b0;
                request_data     <= 32'h0;
                fetch_error      <= 1'b0;
            end
        end
    end

    // The credit bound keeps the queue from overflowing.
    assert property (@(posedge clk) disable iff (rst) cnt <= CNT_W'(QUEUE_DEPTH));
    assert property (@(posedge clk) disable iff (rst) fifo_cnt <= CNT_W'(QUEUE_DEPTH));

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Responder side of the instruction-fetch interface: accepts fetch_addr/fetch_req from the fetch stage and returns request_data/fetch_data_valid in order after a fixed access latency. Holds a word-addressed instruction array that is loaded through a write port. Uses credit-based flow control so the fetch stage can stall on the response side without losing data. Supports a flush that squashes in-flight fetches on redirect.

Parameters:
DEPTH_WORDS, 256, number of 32-bit instruction words in the array (power of two)
LATENCY, 2, cycles from request acceptance to the earliest response (>=1)
QUEUE_DEPTH, 4, maximum outstanding requests (in flight plus queued responses); power of two, >= LATENCY
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
fetch_addr  input  32  byte address of requested instruction
fetch_req  input  1  request valid
fetch_ready  output  1  request accepted this cycle when fetch_req && fetch_ready
request_data  output  32  returned instruction word
fetch_data_valid  output  1  response valid
fetch_error  output  1  response is for a misaligned or out-of-range address; qualified by fetch_data_valid
resp_ready  input  1  consumer takes the response this cycle
flush  input  1  discard all outstanding requests and responses
load_en  input  1  array write enable
load_addr  input  32  byte address for array write
load_data  input  32  word written to array

Behaviour:
- Reset (rst high at a clock edge): fetch_data_valid=0, fetch_error=0, request_data=0, outstanding count=0, latency pipe and response queue emptied. fetch_ready is 0 while rst is high and 1 in the first cycle after. Array contents are not reset.
- Accept: fetch_req && fetch_ready in cycle t. The array is read in cycle t. A load to the same word in the same cycle returns the old word (read before write).
- Address check: index = (fetch_addr - BASE_ADDR) >> 2. Error if fetch_addr[1:0] != 0, fetch_addr < BASE_ADDR, or index >= DEPTH_WORDS. An error response has request_data=0 and fetch_error=1. Errors are still responses and consume a credit.
- Latency: the response travels through a LATENCY-stage shift pipe and then enters the response queue. With the queue empty, fetch_data_valid is first high in cycle t+LATENCY. Back-to-back accepts produce back-to-back responses. Order is strictly preserved.
- Response handshake: the head entry is presented on request_data/fetch_error with fetch_data_valid=1. It is popped on fetch_data_valid && resp_ready. While fetch_data_valid && !resp_ready, all response outputs hold stable.
- Credits: 3-bit-wide-enough counter cnt, range 0..QUEUE_DEPTH.
  - +1 on accept, -1 on pop, unchanged on both together.
  - fetch_ready = (cnt < QUEUE_DEPTH) && !flush.
  - Because of this bound the queue never overflows, so no overflow logic beyond assertion.
- Full: at cnt==QUEUE_DEPTH, fetch_ready=0. A pop in that cycle makes fetch_ready 1 in the next cycle (no same-cycle bypass).
- Empty: no valid responses means fetch_data_valid=0 and request_data holds 0.
- Flush: in a cycle with flush=1:
  - no accept and no pop occur;
  - at the edge, the pipe and queue are cleared and cnt=0;
  - fetch_data_valid is 0 the next cycle;
  - fetch_req in the flush cycle is ignored.
- Flush and rst together: behaves as rst.
- Load port: writes load_data at word index of load_addr when load_en=1. Misaligned or out-of-range loads are ignored. Loads proceed regardless of fetch traffic and flush.
- Pointer wrap: queue read/write pointers wrap modulo QUEUE_DEPTH.

Test Plan:
- Load 0x00000013 at 0x0, 0x00100093 at 0x4; accept 0x0 in cycle 10 with resp_ready=1 -> fetch_data_valid=1 in cycle 12 with request_data=0x00000013, fetch_error=0; then 0x00100093 in cycle 13 for a request in cycle 11.
- Hold resp_ready=0, issue requests every cycle -> exactly 4 accepts, then fetch_ready=0. Raise resp_ready -> 4 responses in order; fetch_ready returns 1 the cycle after the first pop.
- Request 0x2 and 0x400 (DEPTH_WORDS=256) -> two responses with fetch_error=1, request_data=0; cnt returns to 0.
- 3 requests outstanding, assert flush one cycle -> no fetch_data_valid afterward for those requests; new request to 0x4 accepted next cycle returns 0x00100093 after 2 cycles.
- Same cycle: load_en to 0x8 with 0xDEADBEEF and fetch of 0x8 -> fetch returns the prior word; a following fetch returns 0xDEADBEEF.
- Assert rst with queue full and fetch_data_valid=1 -> next cycle all outputs 0, fetch_ready 1 after rst falls; previously loaded array data is still returned.
